// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating counters.
// Fetch lookup is combinational; execute writes resolved outcomes on clk.
module branch_predictor #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int CTR_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bp_en,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] fetch_pc,
  output logic                  pred_hit,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_next_pc,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic                  upd_is_jump,
  input  logic                  upd_taken,
  input  logic [ADDR_WIDTH-1:0] upd_target
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

  localparam logic [CTR_WIDTH-1:0] CTR_MAX     = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_WEAK_T  = CTR_WIDTH'(1) << (CTR_WIDTH - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_WEAK_NT = CTR_WEAK_T - CTR_WIDTH'(1);

  // Entry storage; kept in flops because the lookup must be same-cycle
  logic [DEPTH-1:0]      valid_mem;
  logic [TAG_W-1:0]      tag_mem    [DEPTH];
  logic [ADDR_WIDTH-1:0] target_mem [DEPTH];
  logic [CTR_WIDTH-1:0]  ctr_mem    [DEPTH];

  // Address split; the low two PC bits never participate
  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             unused_pc_bits;

  assign fetch_idx      = fetch_pc[IDX_W+1:2];
  assign fetch_tag      = fetch_pc[ADDR_WIDTH-1:IDX_W+2];
  assign upd_idx        = upd_pc[IDX_W+1:2];
  assign upd_tag        = upd_pc[ADDR_WIDTH-1:IDX_W+2];
  assign unused_pc_bits = ^upd_pc[1:0];

  // Lookup reads pre-update contents, so a same-edge write is seen next cycle
  logic [ADDR_WIDTH-1:0] pc_plus4;
  always_comb begin
    pc_plus4     = fetch_pc + ADDR_WIDTH'(4);
    pred_hit     = valid_mem[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);
    pred_taken   = bp_en && pred_hit && ctr_mem[fetch_idx][CTR_WIDTH-1];
    pred_next_pc = pred_taken ? target_mem[fetch_idx] : pc_plus4;
  end

  // Resolve the single update into one entry write (train on hit, allocate on taken miss)
  logic                  upd_hit;
  logic                  eff_taken;
  logic [CTR_WIDTH-1:0]  cur_ctr;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_target;
  logic [CTR_WIDTH-1:0]  wr_ctr;
  always_comb begin
    upd_hit   = valid_mem[upd_idx] && (tag_mem[upd_idx] == upd_tag);
    eff_taken = upd_is_jump | upd_taken;
    cur_ctr   = ctr_mem[upd_idx];
    wr_en     = 1'b0;
    wr_target = target_mem[upd_idx];
    wr_ctr    = cur_ctr;
    if (upd_valid) begin
      if (upd_hit) begin
        wr_en = 1'b1;
        if (upd_is_jump) begin
          wr_ctr    = CTR_MAX;
          wr_target = upd_target;
        end else if (upd_taken) begin
          wr_ctr    = (cur_ctr == CTR_MAX) ? cur_ctr : cur_ctr + CTR_WIDTH'(1);
          wr_target = upd_target;
        end else begin
          wr_ctr    = (cur_ctr == '0) ? cur_ctr : cur_ctr - CTR_WIDTH'(1);
        end
      end else if (eff_taken) begin
        wr_en     = 1'b1;
        wr_target = upd_target;
        wr_ctr    = upd_is_jump ? CTR_MAX : CTR_WEAK_T;
      end
    end
  end

  // One-hot entry select for the write
  logic [DEPTH-1:0] wr_sel;
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
    assign wr_sel[gi] = wr_en && (upd_idx == IDX_W'(gi));
  end

  // Entry state: async reset, clear wins over a same-edge update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_mem[i]  <= 1'b0;
        tag_mem[i]    <= '0;
        target_mem[i] <= '0;
        ctr_mem[i]    <= CTR_WEAK_NT;
      end
    end else if (clear) begin
      valid_mem <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) begin
          valid_mem[i]  <= 1'b1;
          tag_mem[i]    <= upd_tag;
          target_mem[i] <= wr_target;
          ctr_mem[i]    <= wr_ctr;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor (DEPTH=16, CTR_WIDTH=2).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        bp_en;
  logic        clear;
  logic [31:0] fetch_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_jump;
  logic        upd_taken;
  logic [31:0] upd_target;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic        hit;
    logic        taken;
    logic [31:0] npc;
  } exp_t;
  exp_t sb[$];

  branch_predictor #(.ADDR_WIDTH(32), .DEPTH(16), .CTR_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .bp_en(bp_en), .clear(clear),
    .fetch_pc(fetch_pc), .pred_hit(pred_hit), .pred_taken(pred_taken),
    .pred_next_pc(pred_next_pc), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target)
  );

  always #5 clk = ~clk;

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Drive a fetch PC, push the expectation, then pop and compare the lookup
  task automatic look(input string name, input logic [31:0] pc,
                      input logic h, input logic t, input logic [31:0] n);
    exp_t e;
    fetch_pc = pc;
    sb.push_back('{name, h, t, n});
    #1;
    e = sb.pop_front();
    chk({e.name, ".hit"},   {31'd0, pred_hit},   {31'd0, e.hit});
    chk({e.name, ".taken"}, {31'd0, pred_taken}, {31'd0, e.taken});
    chk({e.name, ".npc"},   pred_next_pc,        e.npc);
  endtask

  // One update pulse across a rising edge
  task automatic upd(input logic [31:0] pc, input logic j, input logic t, input logic [31:0] tgt);
    upd_valid   = 1'b1;
    upd_pc      = pc;
    upd_is_jump = j;
    upd_taken   = t;
    upd_target  = tgt;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bp_en = 1'b1; clear = 1'b0; fetch_pc = 32'h40;
    upd_valid = 1'b0; upd_pc = '0; upd_is_jump = 1'b0; upd_taken = 1'b0; upd_target = '0;
    #2;
    look("t1_reset", 32'h40, 0, 0, 32'h44);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Test 2: conditional taken allocates weakly taken
    upd(32'h40, 0, 1, 32'h100);
    look("t2_alloc", 32'h40, 1, 1, 32'h100);
    bp_en = 1'b0;
    look("t2_bpdis", 32'h40, 1, 0, 32'h44);
    bp_en = 1'b1;

    // Test 3: counter saturation both ways
    upd(32'h40, 0, 0, 32'h0);   look("t3_nt1", 32'h40, 1, 0, 32'h44);
    upd(32'h40, 0, 0, 32'h0);   look("t3_nt2", 32'h40, 1, 0, 32'h44);
    upd(32'h40, 0, 0, 32'h0);   look("t3_nt3", 32'h40, 1, 0, 32'h44);
    upd(32'h40, 0, 1, 32'h100); look("t3_t1",  32'h40, 1, 0, 32'h44);
    upd(32'h40, 0, 1, 32'h100); look("t3_t2",  32'h40, 1, 1, 32'h100);
    for (int i = 0; i < 4; i++) upd(32'h40, 0, 1, 32'h100);
    look("t3_sat", 32'h40, 1, 1, 32'h100);
    upd(32'h40, 0, 0, 32'h0);   look("t3_dn1", 32'h40, 1, 1, 32'h100);
    upd(32'h40, 0, 0, 32'h0);   look("t3_dn2", 32'h40, 1, 0, 32'h44);

    // Test 4: alias replacement and no allocation on not-taken miss
    upd(32'h80, 0, 1, 32'h200);
    look("t4_new", 32'h80, 1, 1, 32'h200);
    look("t4_old", 32'h40, 0, 0, 32'h44);
    upd(32'h3C0, 0, 0, 32'h999);
    look("t4_ntmiss", 32'h3C0, 0, 0, 32'h3C4);
    look("t4_keep",   32'h80,  1, 1, 32'h200);

    // Test 5: jump allocates strongly taken; fall-through wraps
    upd(32'h44, 1, 0, 32'hFFFFFFF0);
    look("t5_jump", 32'h44, 1, 1, 32'hFFFFFFF0);
    upd(32'h44, 0, 0, 32'h0);
    look("t5_max", 32'h44, 1, 1, 32'hFFFFFFF0);
    look("t5_wrap", 32'hFFFFFFFC, 0, 0, 32'h0);

    // Test 6: same-edge update/lookup, then clear beats update
    upd_valid = 1'b1; upd_pc = 32'h48; upd_is_jump = 1'b0; upd_taken = 1'b1; upd_target = 32'h300;
    look("t6_pre", 32'h48, 0, 0, 32'h4C);
    @(posedge clk); #1; upd_valid = 1'b0;
    look("t6_post", 32'h48, 1, 1, 32'h300);
    clear = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h4C; upd_is_jump = 1'b1; upd_taken = 1'b1; upd_target = 32'h500;
    @(posedge clk); #1; upd_valid = 1'b0; clear = 1'b0;
    look("t6_clr80", 32'h80, 0, 0, 32'h84);
    look("t6_clr44", 32'h44, 0, 0, 32'h48);
    look("t6_clr48", 32'h48, 0, 0, 32'h4C);
    look("t6_clr4c", 32'h4C, 0, 0, 32'h50);

    // Async reset mid-cycle clears a live entry before any clock edge
    upd(32'h40, 0, 1, 32'h100);
    look("t1_live", 32'h40, 1, 1, 32'h100);
    rst = 1'b1;
    look("t1_async", 32'h40, 0, 0, 32'h44);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    look("t1_after", 32'h40, 0, 0, 32'h44);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
